// File: rtl/mc_core.sv
// mc_core: multi-cycle core for the 9-bit ISA (opcode[8:6], r1[5:3], r2/imm[2:0]).
// Sequencing is FETCH -> EXEC (-> MEM) with a req/ack data-memory handshake.
module mc_core #(
  parameter int unsigned DW       = 8,
  parameter int unsigned D        = 10,
  parameter int unsigned PROG_LEN = 24,
  parameter int unsigned NREG     = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic [D-1:0]  imem_addr,
  input  logic [8:0]    imem_data,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ack,
  output logic [31:0]   cycle_count
);

  typedef enum logic [2:0] {StIdle, StFetch, StExec, StMem, StDone} state_e;

  localparam logic [2:0] OpXor  = 3'd0;
  localparam logic [2:0] OpBeq  = 3'd1;
  localparam logic [2:0] OpAddi = 3'd2;
  localparam logic [2:0] OpAndi = 3'd3;
  localparam logic [2:0] OpLs   = 3'd4;
  localparam logic [2:0] OpLd   = 3'd5;
  localparam logic [2:0] OpSt   = 3'd6;
  localparam logic [2:0] OpJ    = 3'd7;

  state_e        state_q, state_d;
  logic [D-1:0]  pc_q, pc_d;
  logic [8:0]    instr_q, instr_d;
  logic [31:0]   cyc_q, cyc_d;
  logic [DW-1:0] regs_q [NREG];

  logic          rf_we;
  logic [DW-1:0] rf_wdata;

  // EXEC decodes the live ROM word; MEM works from the copy latched in EXEC.
  logic [8:0]    instr;
  logic [2:0]    op, ra, rb;
  logic [DW-1:0] ra_val, rb_val, imm_s, imm_z;
  logic [D-1:0]  pc_inc, pc_br, pc_j;

  assign instr  = (state_q == StExec) ? imem_data : instr_q;
  assign op     = instr[8:6];
  assign ra     = instr[5:3];
  assign rb     = instr[2:0];
  assign ra_val = regs_q[ra];
  assign rb_val = regs_q[rb];
  assign imm_s  = {{(DW-3){rb[2]}}, rb};
  assign imm_z  = {{(DW-3){1'b0}}, rb};
  assign pc_inc = pc_q + {{(D-1){1'b0}}, 1'b1};
  assign pc_br  = pc_inc + {{(D-3){rb[2]}}, rb};
  assign pc_j   = {{(D-6){1'b0}}, instr[5:0]};

  assign done        = (state_q == StDone);
  assign imem_addr   = pc_q;
  assign dmem_req    = (state_q == StMem);
  assign dmem_we     = dmem_req && (instr_q[8:6] == OpSt);
  assign dmem_addr   = regs_q[instr_q[2:0]];
  assign dmem_wdata  = regs_q[instr_q[5:3]];
  assign cycle_count = cyc_q;

  function automatic logic past_end(input logic [D-1:0] p);
    return 32'(p) >= PROG_LEN;
  endfunction

  // Next-state, PC, register write-back and cycle counter logic.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    cyc_d    = cyc_q;
    rf_we    = 1'b0;
    rf_wdata = '0;
    if ((state_q == StFetch || state_q == StExec || state_q == StMem) &&
        (cyc_q != 32'hFFFF_FFFF)) begin
      cyc_d = cyc_q + 32'd1;
    end
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          pc_d    = '0;
          cyc_d   = '0;
          state_d = StFetch;
        end
      end
      StFetch: state_d = StExec;
      StExec: begin
        instr_d = imem_data;
        pc_d    = pc_inc;
        unique case (op)
          OpXor:  begin rf_we = 1'b1; rf_wdata = ra_val ^ rb_val; end
          OpBeq:  if (ra_val == '0) pc_d = pc_br;
          OpAddi: begin rf_we = 1'b1; rf_wdata = ra_val + imm_s; end
          OpAndi: begin rf_we = 1'b1; rf_wdata = ra_val & imm_z; end
          OpLs:   begin rf_we = 1'b1; rf_wdata = ra_val << rb; end
          OpLd, OpSt: pc_d = pc_q;
          OpJ:    pc_d = pc_j;
        endcase
        if (op == OpLd || op == OpSt) state_d = StMem;
        else state_d = past_end(pc_d) ? StDone : StFetch;
      end
      StMem: begin
        if (dmem_ack) begin
          pc_d = pc_inc;
          if (op == OpLd) begin
            rf_we    = 1'b1;
            rf_wdata = dmem_rdata;
          end
          state_d = past_end(pc_inc) ? StDone : StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, PC, latched instruction, counter and register file.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      instr_q <= '0;
      cyc_q   <= '0;
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cyc_q   <= cyc_d;
      if (rf_we) regs_q[ra] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_mc_core.sv
// tb_mc_core: randomized and directed checks of mc_core against an ISA-level model.
module tb_mc_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;

  logic done_a, req_a, we_a, ack_a;
  logic [9:0] iaddr_a;
  logic [8:0] idata_a, idata_b, idata_c;
  logic [7:0] daddr_a, wdata_a, rdata_a;
  logic [31:0] cc_a, cc_b, cc_c;
  logic done_b, req_b, we_b;
  logic [9:0] iaddr_b;
  logic [7:0] daddr_b, wdata_b;
  logic done_c, req_c, we_c;
  logic [11:0] iaddr_c;
  logic [15:0] daddr_c, wdata_c;

  mc_core #(.DW(8), .D(10), .PROG_LEN(24)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .done(done_a), .imem_addr(iaddr_a),
    .imem_data(idata_a), .dmem_req(req_a), .dmem_we(we_a), .dmem_addr(daddr_a),
    .dmem_wdata(wdata_a), .dmem_rdata(rdata_a), .dmem_ack(ack_a), .cycle_count(cc_a));

  mc_core #(.DW(8), .D(10), .PROG_LEN(3)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .done(done_b), .imem_addr(iaddr_b),
    .imem_data(idata_b), .dmem_req(req_b), .dmem_we(we_b), .dmem_addr(daddr_b),
    .dmem_wdata(wdata_b), .dmem_rdata(8'h00), .dmem_ack(1'b0), .cycle_count(cc_b));

  mc_core #(.DW(16), .D(12), .PROG_LEN(24)) u_c (
    .clk(clk), .reset(reset), .start(start_c), .done(done_c), .imem_addr(iaddr_c),
    .imem_data(idata_c), .dmem_req(req_c), .dmem_we(we_c), .dmem_addr(daddr_c),
    .dmem_wdata(wdata_c), .dmem_rdata(16'h0000), .dmem_ack(1'b0), .cycle_count(cc_c));

  int checks = 0;
  int errors = 0;

  // Shared program ROM; addresses beyond it read as xor r0,r0.
  logic [8:0] rom [64];
  function automatic logic [8:0] rom_rd(int unsigned a);
    return (a < 64) ? rom[a] : 9'h000;
  endfunction

  always @(posedge clk) begin
    idata_a <= rom_rd(32'(iaddr_a));
    idata_b <= rom_rd(32'(iaddr_b));
    idata_c <= rom_rd(32'(iaddr_c));
  end

  // Data memory for u_a with programmable ack delay and a transaction log.
  typedef struct packed {logic we; logic [7:0] addr; logic [7:0] wdata;} txn_t;
  logic [7:0] dmem [256];
  int   ack_delay = 0;
  int   wait_cnt = 0;
  int   unstable = 0;
  int   req_after_ack = 0;
  logic ack_prev = 1'b0;
  txn_t hold;
  txn_t txq[$];

  assign ack_a   = req_a && (wait_cnt >= ack_delay);
  assign rdata_a = dmem[daddr_a];

  always @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 0;
      ack_prev <= 1'b0;
    end else begin
      ack_prev <= ack_a;
      if (ack_prev && req_a) req_after_ack <= req_after_ack + 1;
      if (req_a) begin
        if (wait_cnt == 0) hold <= '{we_a, daddr_a, wdata_a};
        else if ({we_a, daddr_a, wdata_a} != hold) unstable <= unstable + 1;
        if (ack_a) begin
          wait_cnt <= 0;
          txq.push_back('{we_a, daddr_a, (we_a ? wdata_a : 8'h00)});
          if (we_a) dmem[daddr_a] <= wdata_a;
        end else begin
          wait_cnt <= wait_cnt + 1;
        end
      end
    end
  end

  // Reference model state: registers per instance, memory image for u_a.
  longint mreg [3][8];
  longint mmem [256];
  longint exp_pcs[$];
  longint obs_pcs[$];
  txn_t   exp_tx[$];
  int     exp_cyc;
  longint exp_fpc;

  function automatic int dw_of(int w); return (w == 2) ? 16 : 8; endfunction
  function automatic int d_of(int w); return (w == 2) ? 12 : 10; endfunction
  function automatic int pl_of(int w); return (w == 1) ? 3 : 24; endfunction

  function automatic logic [8:0] ins(int op, int a, int b);
    return {op[2:0], a[2:0], b[2:0]};
  endfunction

  function automatic logic get_done(int w);
    case (w)
      0: return done_a;
      1: return done_b;
      default: return done_c;
    endcase
  endfunction

  function automatic longint get_iaddr(int w);
    case (w)
      0: return longint'(iaddr_a);
      1: return longint'(iaddr_b);
      default: return longint'(iaddr_c);
    endcase
  endfunction

  function automatic logic [31:0] get_cc(int w);
    case (w)
      0: return cc_a;
      1: return cc_b;
      default: return cc_c;
    endcase
  endfunction

  function automatic logic [15:0] get_reg(int w, int i);
    case (w)
      0: return 16'(u_a.regs_q[i]);
      1: return 16'(u_b.regs_q[i]);
      default: return u_c.regs_q[i];
    endcase
  endfunction

  task automatic set_start(int w, logic v);
    case (w)
      0: start_a = v;
      1: start_b = v;
      default: start_c = v;
    endcase
  endtask

  task automatic clear_rom();
    for (int k = 0; k < 64; k++) rom[k] = 9'h000;
  endtask

  task automatic zero_model();
    for (int w = 0; w < 3; w++) for (int i = 0; i < 8; i++) mreg[w][i] = 0;
  endtask

  // Instruction-level interpreter: executes the ROM from PC 0 until PC >= PROG_LEN.
  task automatic model(input int w, input int delay, output bit ok);
    longint dm, pm, pc, npc, simm, addr;
    logic [8:0] iw;
    int op, a, b;
    dm = (longint'(1) << dw_of(w)) - 1;
    pm = (longint'(1) << d_of(w)) - 1;
    pc = 0;
    exp_cyc = 0;
    exp_pcs.delete();
    exp_tx.delete();
    ok = 1'b0;
    for (int s = 0; s < 300 && !ok; s++) begin
      iw = rom_rd(32'(pc));
      op = int'(iw[8:6]);
      a  = int'(iw[5:3]);
      b  = int'(iw[2:0]);
      simm = (b >= 4) ? longint'(b - 8) : longint'(b);
      exp_pcs.push_back(pc);
      npc = (pc + 1) & pm;
      exp_cyc += 2;
      case (op)
        0: mreg[w][a] = mreg[w][a] ^ mreg[w][b];
        1: if (mreg[w][a] == 0) npc = (pc + 1 + simm) & pm;
        2: mreg[w][a] = (mreg[w][a] + simm) & dm;
        3: mreg[w][a] = mreg[w][a] & longint'(b);
        4: mreg[w][a] = (mreg[w][a] << b) & dm;
        5: begin
          exp_cyc += 1 + delay;
          addr = mreg[w][b];
          mreg[w][a] = mmem[int'(addr)];
          exp_tx.push_back('{1'b0, 8'(addr), 8'h00});
        end
        6: begin
          exp_cyc += 1 + delay;
          addr = mreg[w][b];
          mmem[int'(addr)] = mreg[w][a];
          exp_tx.push_back('{1'b1, 8'(addr), 8'(mreg[w][a])});
        end
        default: npc = longint'(iw[5:0]);
      endcase
      pc = npc;
      if (pc >= longint'(pl_of(w))) ok = 1'b1;
    end
    exp_fpc = pc;
  endtask

  // Start instance w, run to done, and compare everything against the model.
  task automatic run_prog(input int w, input int delay, input bit poke);
    int cycles, base_tx, base_unst, base_raa, bad;
    ack_delay = delay;
    base_tx   = txq.size();
    base_unst = unstable;
    base_raa  = req_after_ack;
    obs_pcs.delete();
    @(negedge clk);
    set_start(w, 1'b1);
    @(negedge clk);
    set_start(w, 1'b0);
    checks++;
    if (get_cc(w) !== 32'd0 || get_done(w) !== 1'b0)
      $display("FAIL start_clear w=%0d: cycle_count=%0d done=%b, required 0 and 0",
               w, get_cc(w), get_done(w));
    if (get_cc(w) !== 32'd0 || get_done(w) !== 1'b0) errors++;
    cycles = 0;
    while (!get_done(w) && cycles < 3000) begin
      if (obs_pcs.size() == 0 || obs_pcs[$] != get_iaddr(w)) obs_pcs.push_back(get_iaddr(w));
      if (poke && cycles == 1) set_start(w, 1'b1);
      if (poke && cycles == 2) set_start(w, 1'b0);
      @(negedge clk);
      cycles++;
    end
    checks++;
    if (cycles !== exp_cyc) begin
      errors++;
      $display("FAIL latency w=%0d: got %0d cycles, required %0d", w, cycles, exp_cyc);
    end
    checks++;
    if (get_cc(w) !== 32'(exp_cyc)) begin
      errors++;
      $display("FAIL cycle_count w=%0d: got %0d, required %0d", w, get_cc(w), exp_cyc);
    end
    checks++;
    if (get_iaddr(w) !== exp_fpc) begin
      errors++;
      $display("FAIL final_pc w=%0d: got %0d, required %0d", w, get_iaddr(w), exp_fpc);
    end
    bad = -1;
    for (int i = 0; i < exp_pcs.size() && i < obs_pcs.size(); i++)
      if (bad < 0 && obs_pcs[i] != exp_pcs[i]) bad = i;
    checks++;
    if (obs_pcs.size() != exp_pcs.size() || bad >= 0) begin
      errors++;
      $display("FAIL pc_trace w=%0d: got %0d fetches (first diff %0d), required %0d",
               w, obs_pcs.size(), bad, exp_pcs.size());
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (get_reg(w, i) !== 16'(mreg[w][i])) begin
        errors++;
        $display("FAIL reg w=%0d R%0d: got %h, required %h", w, i, get_reg(w, i),
                 16'(mreg[w][i]));
      end
    end
    if (w == 0) begin
      checks++;
      if (txq.size() - base_tx != exp_tx.size()) begin
        errors++;
        $display("FAIL txn_count: got %0d, required %0d", txq.size() - base_tx, exp_tx.size());
      end else begin
        for (int i = 0; i < exp_tx.size(); i++) begin
          checks++;
          if (txq[base_tx + i] !== exp_tx[i]) begin
            errors++;
            $display("FAIL txn %0d: got %h, required %h", i, txq[base_tx + i], exp_tx[i]);
          end
        end
      end
      checks++;
      if (unstable !== base_unst) begin
        errors++;
        $display("FAIL req_stable: %0d unstable cycles, required 0", unstable - base_unst);
      end
      checks++;
      if (req_after_ack !== base_raa) begin
        errors++;
        $display("FAIL req_drop: req high %0d times after ack, required 0",
                 req_after_ack - base_raa);
      end
    end
  endtask

  task automatic gen_random(input bit allow_mem);
    int r, op, t;
    clear_rom();
    for (int k = 0; k < 24; k++) begin
      r = int'($urandom_range(0, 15));
      if (r >= 14) begin
        t = int'($urandom_range(k + 1, 40));
        rom[k] = ins(7, t / 8, t % 8);
      end else begin
        op = r % 7;
        if (!allow_mem && op >= 5) op = op - 3;
        rom[k] = ins(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    zero_model();
    checks++;
    if ({done_a, done_b, done_c} !== 3'b000) begin
      errors++;
      $display("FAIL reset_done: got %b, required 000", {done_a, done_b, done_c});
    end
    checks++;
    if ({req_a, we_a, req_b, req_c} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_dmem: req/we got %b, required 0000", {req_a, we_a, req_b, req_c});
    end
    checks++;
    if (cc_a !== 0 || cc_b !== 0 || cc_c !== 0) begin
      errors++;
      $display("FAIL reset_count: got %0d %0d %0d, required 0", cc_a, cc_b, cc_c);
    end
    checks++;
    if (iaddr_a !== 0 || iaddr_b !== 0 || iaddr_c !== 0) begin
      errors++;
      $display("FAIL reset_pc: got %0d %0d %0d, required 0", iaddr_a, iaddr_b, iaddr_c);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_alu_seq();
    bit ok;
    clear_rom();
    rom[0] = ins(2, 1, 3);
    rom[1] = ins(2, 1, 7);
    rom[2] = ins(4, 1, 2);
    model(1, 0, ok);
    run_prog(1, 0, 1'b0);
    checks++;
    if (get_reg(1, 1) !== 16'd8 || cc_b !== 32'd6 || done_b !== 1'b1) begin
      errors++;
      $display("FAIL alu_seq: R1=%0d count=%0d done=%b, required 8 6 1", get_reg(1, 1), cc_b,
               done_b);
    end
  endtask

  task automatic test_mem_round_trip();
    bit ok;
    int b0;
    clear_rom();
    rom[0]  = ins(0, 2, 2);
    rom[1]  = ins(0, 3, 3);
    rom[2]  = ins(2, 2, 3);
    rom[3]  = ins(2, 2, 2);
    rom[4]  = ins(2, 3, 3);
    rom[5]  = ins(2, 3, 3);
    rom[6]  = ins(2, 3, 1);
    rom[7]  = ins(6, 3, 2);
    rom[8]  = ins(0, 3, 3);
    rom[9]  = ins(5, 3, 2);
    rom[10] = ins(7, 7, 7);
    dmem[5] = 8'hA5;
    for (int i = 0; i < 256; i++) mmem[i] = longint'(dmem[i]);
    b0 = txq.size();
    model(0, 2, ok);
    run_prog(0, 2, 1'b0);
    checks++;
    if (txq[b0] !== txn_t'{1'b1, 8'd5, 8'd7}) begin
      errors++;
      $display("FAIL mem_store: got %h, required we=1 addr=5 wdata=7", txq[b0]);
    end
    checks++;
    if (get_reg(0, 3) !== 16'd7) begin
      errors++;
      $display("FAIL mem_load: R3=%0d, required 7", get_reg(0, 3));
    end
  endtask

  task automatic test_branch();
    bit ok;
    clear_rom();
    rom[0] = ins(0, 1, 1);
    rom[4] = ins(1, 1, 2);
    rom[7] = ins(7, 7, 7);
    model(0, 0, ok);
    run_prog(0, 0, 1'b0);
    checks++;
    if (obs_pcs.size() < 6 || obs_pcs[5] !== 64'd7) begin
      errors++;
      $display("FAIL beq_taken: fetch after PC4 at %0d, required 7", obs_pcs[5]);
    end
    rom[1] = ins(2, 1, 1);
    rom[5] = ins(7, 7, 7);
    model(0, 0, ok);
    run_prog(0, 0, 1'b0);
    checks++;
    if (obs_pcs.size() < 6 || obs_pcs[5] !== 64'd5) begin
      errors++;
      $display("FAIL beq_not_taken: fetch after PC4 at %0d, required 5", obs_pcs[5]);
    end
    clear_rom();
    rom[0] = ins(0, 1, 1);
    rom[1] = ins(1, 1, 4);
    model(0, 0, ok);
    run_prog(0, 0, 1'b0);
    checks++;
    if (iaddr_a !== 10'd1022 || done_a !== 1'b1) begin
      errors++;
      $display("FAIL beq_wrap: pc=%0d done=%b, required 1022 1", iaddr_a, done_a);
    end
  endtask

  task automatic test_jump();
    bit ok;
    clear_rom();
    rom[0]  = ins(7, 2, 4);
    rom[20] = ins(7, 7, 7);
    model(0, 0, ok);
    run_prog(0, 0, 1'b0);
    checks++;
    if (obs_pcs.size() < 2 || obs_pcs[1] !== 64'd20 || iaddr_a !== 10'd63) begin
      errors++;
      $display("FAIL jump: second fetch %0d final pc %0d, required 20 and 63", obs_pcs[1],
               iaddr_a);
    end
  endtask

  task automatic test_start_ignored();
    bit ok;
    clear_rom();
    rom[0] = ins(2, 1, 1);
    rom[1] = ins(2, 1, 1);
    rom[2] = ins(7, 7, 7);
    model(0, 0, ok);
    run_prog(0, 0, 1'b1);
  endtask

  task automatic test_reset_mid_mem();
    int n;
    clear_rom();
    rom[0] = ins(6, 0, 0);
    ack_delay = 1000;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n = 0;
    while (!req_a && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_a !== 1'b1) begin
      errors++;
      $display("FAIL mid_mem_entry: req=%b, required 1", req_a);
    end
    reset = 1'b1;
    @(negedge clk);
    zero_model();
    checks++;
    if (req_a !== 1'b0 || we_a !== 1'b0 || done_a !== 1'b0 || cc_a !== 0 || iaddr_a !== 0) begin
      errors++;
      $display("FAIL mid_mem_reset: req=%b we=%b done=%b count=%0d pc=%0d, required all 0",
               req_a, we_a, done_a, cc_a, iaddr_a);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (get_reg(0, i) !== 16'd0) begin
        errors++;
        $display("FAIL mid_mem_regs R%0d: got %h, required 0", i, get_reg(0, i));
      end
    end
    reset = 1'b0;
    ack_delay = 0;
    @(negedge clk);
  endtask

  task automatic test_wide();
    bit ok;
    clear_rom();
    rom[0] = ins(0, 1, 1);
    rom[1] = ins(2, 1, 1);
    rom[2] = ins(4, 1, 7);
    rom[3] = ins(4, 1, 7);
    rom[4] = ins(4, 1, 1);
    rom[5] = ins(2, 1, 7);
    rom[6] = ins(2, 1, 1);
    rom[7] = ins(7, 7, 7);
    model(2, 0, ok);
    run_prog(2, 0, 1'b0);
    checks++;
    if (get_reg(2, 1) !== 16'h8000) begin
      errors++;
      $display("FAIL wide_wrap: R1=%h, required 8000", get_reg(2, 1));
    end
    clear_rom();
    rom[0] = ins(2, 1, 1);
    rom[1] = ins(7, 7, 7);
    model(2, 0, ok);
    run_prog(2, 0, 1'b0);
    checks++;
    if (get_reg(2, 1) !== 16'h8001 || cc_c !== 32'd4) begin
      errors++;
      $display("FAIL wide_restart: R1=%h count=%0d, required 8001 and 4", get_reg(2, 1), cc_c);
    end
  endtask

  task automatic test_random();
    bit ok;
    int w, tries, delay;
    longint sv [8];
    for (int n = 0; n < 24; n++) begin
      w = (n % 3 == 2) ? 2 : 0;
      for (int i = 0; i < 8; i++) sv[i] = mreg[w][i];
      ok = 1'b0;
      tries = 0;
      delay = 0;
      while (!ok && tries < 50) begin
        for (int i = 0; i < 8; i++) mreg[w][i] = sv[i];
        gen_random(w == 0);
        for (int i = 0; i < 256; i++) begin
          dmem[i] = 8'($urandom);
          mmem[i] = longint'(dmem[i]);
        end
        delay = int'($urandom_range(0, 3));
        model(w, delay, ok);
        tries++;
      end
      if (ok) run_prog(w, delay, 1'b0);
      else for (int i = 0; i < 8; i++) mreg[w][i] = sv[i];
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) dmem[i] = 8'($urandom);
    clear_rom();
    test_reset();
    test_alu_seq();
    test_mem_round_trip();
    test_branch();
    test_jump();
    test_start_ignored();
    test_reset_mid_mem();
    test_wide();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_core.md
Name: mc_core

Overview:
- Parametrised multi-cycle successor to the single-cycle 9-bit-ISA core.
- Executes the same 8-opcode instruction format (opcode[8:6], r1[5:3], r2/imm[2:0]) through an explicit FETCH/EXEC/MEM state machine.
- Generalised in data width, PC width and program length; a parameter replaces the hardcoded done addresses.
- Instruction ROM and data memory sit outside the block. Data memory uses a req/ack handshake, so variable-latency memories are supported.

Parameters:
- DW, 8, data/register width (>=4)
- D, 10, program counter width
- PROG_LEN, 24, done asserts when PC >= PROG_LEN
- NREG, 8, register count (fixed by 3-bit register fields)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  begin execution at PC 0 (sampled in IDLE/DONE only)
- done  out  1  high in DONE state
- imem_addr  out  D  instruction address (= PC)
- imem_data  in  9  instruction, valid one cycle after imem_addr
- dmem_req  out  1  data access request
- dmem_we  out  1  1=store, 0=load (valid with req)
- dmem_addr  out  DW  R[r2]
- dmem_wdata  out  DW  R[r1]
- dmem_rdata  in  DW  load data, valid with ack
- dmem_ack  in  1  completes access
- cycle_count  out  32  cycles since start

Behaviour:
- Reset (synchronous, active-high): state=IDLE, PC=0, all regs=0, done=0, dmem_req=0, dmem_we=0, cycle_count=0. Reset dominates every other input, including mid-MEM; dmem_req drops at that edge.
- State IDLE: start=1 -> PC=0, cycle_count=0, go FETCH.
- State FETCH: imem_addr=PC, go EXEC.
- State EXEC: decode imem_data.
  - Non-memory ops: write back and update PC this cycle. Next state is DONE if new PC >= PROG_LEN, else FETCH.
  - ld/st: go MEM.
- Opcodes (imm3 = instr[2:0]):
  - 000 xor: R[r1] = R[r1] ^ R[r2]
  - 001 beq: if R[r1]==0, PC = PC+1+sext(imm3), else PC+1
  - 010 addi: R[r1] = R[r1] + sext(imm3), modulo 2^DW
  - 011 andi: R[r1] = R[r1] & zext(imm3)
  - 100 ls: R[r1] = R[r1] << imm3, truncated to DW
  - 101 ld: R[r1] = mem[R[r2]]
  - 110 st: mem[R[r2]] = R[r1]
  - 111 j: PC = zext(instr[5:0])
- PC arithmetic: modulo 2^D. beq backward past 0 wraps.
- State MEM:
  - dmem_req=1; dmem_we, dmem_addr and dmem_wdata stay stable until the ack cycle.
  - On dmem_ack=1, same edge: ld writes dmem_rdata, PC+1, req deasserts next cycle, and next state is DONE/FETCH by the same PROG_LEN rule.
  - ack outside MEM is ignored. No timeout.
- Latency: ALU/branch/jump = 2 cycles. ld/st = 3 cycles with ack in the first MEM cycle; each cycle of ack delay adds 1.
- State DONE: done=1, PC and regs held. start=1 -> PC=0, cycle_count=0, go FETCH, done drops next cycle. Registers are retained across restart.
- start while FETCH/EXEC/MEM: ignored.
- cycle_count: +1 every cycle in FETCH/EXEC/MEM, frozen in IDLE/DONE, saturates at 2^32-1.
- PROG_LEN=0: the first EXEC always transitions to DONE.

Test Plan:
- Reset then start; program addi r1,3; addi r1,-1; ls r1,2; PROG_LEN=3 -> R1=8, done=1 after 6 cycles, cycle_count=6.
- Memory round trip, ack delayed 2 cycles:
  - addi r2,5; addi r3,7; st r3,(r2); xor r3,r3; ld r3,(r2).
  - Required: dmem_req held stable 3 cycles per access; store addr=5, wdata=7; R3=7 at end.
- Branch:
  - Taken (R1==0) with beq r1,+2 at PC 4 -> next fetch addr 7.
  - Not taken (R1=1) -> next fetch addr 5.
  - beq r1,-4 at PC 1 with R1=0 -> PC wraps to 1022 (D=10).
- j 20 with PROG_LEN=24 -> imem_addr=20 next FETCH. j 63 -> immediate DONE.
- Reset asserted during MEM (ack withheld) -> next cycle dmem_req=0, state IDLE, regs 0. start during EXEC -> no effect on PC.
- DW=16, D=12 instance: addi 0x7FFF+1 via ls/addi sequence wraps to 0x8000. Restart from DONE keeps register values and clears cycle_count.
